// File: rtl/ev22_pkg.sv
// Shared EV22 core definitions: opcode width, opcode constants and fetch-state encoding.
// Used by the fetch sequencer and the instruction decoder.
package ev22_pkg;

    localparam int unsigned OP_W = 8;

    localparam logic [OP_W-1:0] OP_NOP  = 8'h00;
    localparam logic [OP_W-1:0] OP_ADD  = 8'h01;
    localparam logic [OP_W-1:0] OP_SUB  = 8'h02;
    localparam logic [OP_W-1:0] OP_INC0 = 8'h03;
    localparam logic [OP_W-1:0] OP_INC1 = 8'h04;
    localparam logic [OP_W-1:0] OP_HALT = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StCapture,
        StIssue,
        StHalt,
        StPause
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-side bus: program ROM read port, opcode handshake to the decoder and jump redirect.
// master = fetch sequencer, slave = ROM/decoder side.
interface instr_fetch_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned OP_W   = 8
);
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [OP_W-1:0]   rom_data;
    logic [OP_W-1:0]   opcode;
    logic              op_valid;
    logic              op_ready;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;

    modport master (
        output rom_en, rom_addr, opcode, op_valid,
        input  rom_data, op_ready, jump_en, jump_addr
    );

    modport slave (
        input  rom_en, rom_addr, opcode, op_valid,
        output rom_data, op_ready, jump_en, jump_addr
    );
endinterface

// File: rtl/instr_fetch_pc_counter.sv
// Program counter: synchronous clear, load, increment with wrap at PROG_LEN-1, else hold.
module pc_counter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned PROG_LEN = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] count
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PROG_LEN - 1);

    logic [ADDR_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (inc) begin
            count_d = (count_q == LAST) ? '0 : count_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: walks the PC over a synchronous ROM and issues opcodes to the
// decoder. Optional single-step mode (PAUSE state, step input) enabled by FETCH_STEP_EN.
module instr_fetch
    import ev22_pkg::*;
#(
    parameter int unsigned     ADDR_W   = 8,
    parameter int unsigned     PROG_LEN = 256,
    parameter logic [OP_W-1:0] HALT_OP  = OP_HALT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef FETCH_STEP_EN
    input  logic              step,
`endif
    instr_fetch_if.master     bus,
    output logic [ADDR_W-1:0] pc,
    output logic              running,
    output logic              halted
);
    fetch_state_e    state_q, state_d;
    logic [OP_W-1:0] opcode_q, opcode_d;
    logic            op_valid_q, op_valid_d;
    logic            pc_load, pc_inc;
    logic [ADDR_W-1:0] pc_val;
    logic            jump_ok;
    logic            step_go;
    fetch_state_e    after_issue;

`ifdef FETCH_STEP_EN
    assign step_go     = step;
    assign after_issue = StPause;
`else
    assign step_go     = 1'b0;
    assign after_issue = StFetch;
`endif

    assign jump_ok = 32'(bus.jump_addr) < PROG_LEN;

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        op_valid_d = op_valid_q;
        pc_load    = 1'b0;
        pc_val     = '0;
        pc_inc     = 1'b0;
        bus.rom_en = 1'b0;
        unique case (state_q)
            StIdle, StHalt: begin
                if (start) begin
                    pc_load = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                bus.rom_en = 1'b1;
                state_d    = StCapture;
            end
            StCapture: begin
                // HALT opcode is consumed here and never reaches the decoder
                if (bus.rom_data == HALT_OP) begin
                    state_d = StHalt;
                end else begin
                    opcode_d   = bus.rom_data;
                    op_valid_d = 1'b1;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                if (op_valid_q && bus.op_ready) begin
                    op_valid_d = 1'b0;
                    if (bus.jump_en && !jump_ok) begin
                        state_d = StHalt;
                    end else if (bus.jump_en) begin
                        pc_load = 1'b1;
                        pc_val  = bus.jump_addr;
                        state_d = after_issue;
                    end else begin
                        pc_inc  = 1'b1;
                        state_d = after_issue;
                    end
                end
            end
            StPause: begin
                if (step_go) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            opcode_q   <= '0;
            op_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            op_valid_q <= op_valid_d;
        end
    end

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .PROG_LEN (PROG_LEN)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_load),
        .load_val (pc_val),
        .inc      (pc_inc),
        .count    (pc)
    );

    assign bus.rom_addr = pc;
    assign bus.opcode   = opcode_q;
    assign bus.op_valid = op_valid_q;
    assign running      = state_q inside {StFetch, StCapture, StIssue, StPause};
    assign halted       = (state_q == StHalt);
endmodule
